// File: rtl/button_conditioner.sv
// Two-button front end: synchronise, debounce and edge-detect raw push-buttons, with optional
// auto-repeat on move; select wins when both would strobe in the same cycle.
module button_conditioner #(
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned REPEAT_EN     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic move_n,
  input  logic select_n,
  output logic move_pulse,
  output logic select_pulse,
  output logic move_held,
  output logic select_held
);

  localparam int unsigned DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

  localparam logic [DbW-1:0]  DbLast     = DbW'(DB_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);
  localparam bit              RepOn      = (REPEAT_EN != 0);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  // Bit 0 is move, bit 1 is select throughout.
  logic [1:0]      raw_n;
  logic [1:0]      sync1_n;
  logic [1:0]      sync2_n;
  logic [1:0]      level;
  logic [1:0]      differs;
  logic [1:0]      toggle;
  logic [1:0]      press;
  logic [DbW-1:0]  db_cnt [2];
  logic            move_release;
  logic            rep_due;
  logic            move_fire;
  rep_state_e      rep_state;
  logic [RepW-1:0] rep_cnt;
  logic            move_pulse_q;
  logic            select_pulse_q;

  assign raw_n = {select_n, move_n};

  always_comb begin
    differs = '0;
    toggle  = '0;
    press   = '0;
    for (int b = 0; b < 2; b++) begin
      // Synchronised sample is active low, debounced level active high.
      differs[b] = (sync2_n[b] == level[b]);
      toggle[b]  = differs[b] && (db_cnt[b] == DbLast);
      press[b]   = toggle[b] && !level[b];
    end
    move_release = toggle[0] && level[0];

    rep_due = 1'b0;
    unique case (rep_state)
      StDelay:  rep_due = (rep_cnt == DelayLast);
      StRepeat: rep_due = (rep_cnt == PeriodLast);
      default:  rep_due = 1'b0;
    endcase

    // A colliding select press drops the move strobe outright.
    move_fire = (press[0] || (rep_due && !move_release && !level[1])) && !press[1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_n        <= '1;
      sync2_n        <= '1;
      level          <= '0;
      db_cnt[0]      <= '0;
      db_cnt[1]      <= '0;
      move_pulse_q   <= 1'b0;
      select_pulse_q <= 1'b0;
      rep_state      <= StIdle;
      rep_cnt        <= '0;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;

      for (int b = 0; b < 2; b++) begin
        if (toggle[b]) begin
          level[b]  <= !level[b];
          db_cnt[b] <= '0;
        end else if (differs[b]) begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end else begin
          db_cnt[b] <= '0;
        end
      end

      move_pulse_q   <= move_fire;
      select_pulse_q <= press[1];

      unique case (rep_state)
        StIdle: begin
          if (press[0] && RepOn) begin
            rep_state <= StDelay;
            rep_cnt   <= '0;
          end
        end
        StDelay: begin
          if (move_release) begin
            rep_state <= StIdle;
            rep_cnt   <= '0;
          end else if (rep_due) begin
            rep_state <= StRepeat;
            rep_cnt   <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        StRepeat: begin
          if (move_release) begin
            rep_state <= StIdle;
            rep_cnt   <= '0;
          end else if (rep_due) begin
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: begin
          rep_state <= StIdle;
          rep_cnt   <= '0;
        end
      endcase
    end
  end

  assign move_pulse   = move_pulse_q;
  assign select_pulse = select_pulse_q;
  assign move_held    = level[0];
  assign select_held  = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3;
// a second instance with auto-repeat disabled shares the same stimulus.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic move_n;
  logic select_n;
  logic move_pulse;
  logic select_pulse;
  logic move_held;
  logic select_held;
  logic nr_move_pulse;
  logic nr_select_pulse;
  logic nr_move_held;
  logic nr_select_held;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3),
    .REPEAT_EN    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .move_n      (move_n),
    .select_n    (select_n),
    .move_pulse  (move_pulse),
    .select_pulse(select_pulse),
    .move_held   (move_held),
    .select_held (select_held)
  );

  button_conditioner #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3),
    .REPEAT_EN    (0)
  ) dut_norep (
    .clk         (clk),
    .rst         (rst),
    .move_n      (move_n),
    .select_n    (select_n),
    .move_pulse  (nr_move_pulse),
    .select_pulse(nr_select_pulse),
    .move_held   (nr_move_held),
    .select_held (nr_select_held)
  );

  // cyc counts rising edges; values are sampled 1 time unit after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
      $error("%s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b0;
    move_n   = 1'b1;
    select_n = 1'b1;
    tick();
    tick();
    check("rst_move_pulse", move_pulse, 1'b0);
    check("rst_select_pulse", select_pulse, 1'b0);
    check("rst_move_held", move_held, 1'b0);
    check("rst_select_held", select_held, 1'b0);
    check("rst_nr_move_held", nr_move_held, 1'b0);
    rst = 1'b1;

    // Move pressed from edge 10: press at 15, repeats at 23, 26, 29, 32; release sampled from
    // edge 30 lands at 35, where it also cancels the due repeat.
    run_to(9);
    move_n = 1'b0;
    for (int c = 10; c <= 45; c++) begin
      tick();
      check("rep_move_pulse", move_pulse, c inside {15, 23, 26, 29, 32});
      check("rep_move_held", move_held, c >= 15 && c < 35);
      check("rep_select_pulse", select_pulse, 1'b0);
      check("norep_move_pulse", nr_move_pulse, c == 15);
      if (c == 29) move_n = 1'b1;
    end

    // Select low for three samples only: too short to be accepted.
    run_to(49);
    select_n = 1'b0;
    for (int c = 50; c <= 62; c++) begin
      tick();
      check("glitch_select_pulse", select_pulse, 1'b0);
      check("glitch_select_held", select_held, 1'b0);
      if (c == 52) select_n = 1'b1;
    end

    // Both fall together from edge 65: only select strobes at 70; repeats muted while select held.
    run_to(64);
    move_n   = 1'b0;
    select_n = 1'b0;
    for (int c = 65; c <= 95; c++) begin
      tick();
      check("both_select_pulse", select_pulse, c == 70);
      check("both_move_pulse", move_pulse, 1'b0);
      check("both_nr_move_pulse", nr_move_pulse, 1'b0);
      check("both_move_held", move_held, c >= 70 && c < 91);
      check("both_select_held", select_held, c >= 70 && c < 91);
      if (c == 85) begin
        move_n   = 1'b1;
        select_n = 1'b1;
      end
    end

    // Reset at edge 104 aborts the debounce due at 105; re-debounce from edge 105 gives 110.
    run_to(99);
    move_n = 1'b0;
    for (int c = 100; c <= 125; c++) begin
      tick();
      check("rst_mid_move_pulse", move_pulse, c == 110);
      check("rst_mid_move_held", move_held, c >= 110 && c < 118);
      if (c == 103) rst = 1'b0;
      if (c == 104) rst = 1'b1;
      if (c == 112) move_n = 1'b1;
    end

    // Bounce: low at 130-131, high at 132, stable low from 133 -> single press at 138.
    run_to(129);
    move_n = 1'b0;
    for (int c = 130; c <= 145; c++) begin
      tick();
      check("bounce_move_pulse", move_pulse, c == 138);
      check("bounce_move_held", move_held, c >= 138);
      if (c == 131) move_n = 1'b1;
      if (c == 132) move_n = 1'b0;
    end
    move_n = 1'b1;
    run_to(165);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
